// File: rtl/dec_pkg.sv
// Shared definitions for the decode stage: widths, instruction field
// positions, immediate-extension encodings and the extender function.
package dec_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_CNT = 32;
    localparam int ADDR_W  = 5;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IMM_ZERO = 2'b00,   // {16'b0, imm}
        IMM_SIGN = 2'b01,   // sign-extended imm
        IMM_HI   = 2'b10,   // imm placed in the upper half
        IMM_BR   = 2'b11    // sign-extended imm, word offset (<<2)
    } imm_ext_e;

    function automatic logic [DATA_W-1:0] extend_imm(input logic [15:0] imm,
                                                     input imm_ext_e    mode);
        logic [DATA_W-1:0] res;
        case (mode)
            IMM_ZERO: res = {16'b0, imm};
            IMM_SIGN: res = {{16{imm[15]}}, imm};
            IMM_HI:   res = {imm, 16'b0};
            default:  res = {{14{imm[15]}}, imm, 2'b00};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dec_if.sv
// Fetch/write-back facing signal bundle of the decode stage.
// master = driver of instruction, control and write-back; slave = dec_stage.
interface dec_if;
    import dec_pkg::*;

    logic [DATA_W-1:0] Instr;
    logic              Instr_valid;
    logic              Stall;
    logic              Flush;
    logic              RF_B_sel;
    logic [1:0]        ImmExt;
    logic              RF_WrEn;
    logic [ADDR_W-1:0] RF_WrAddr;
    logic [DATA_W-1:0] RF_WrData;
    logic [DATA_W-1:0] RF_A;
    logic [DATA_W-1:0] RF_B;
    logic [DATA_W-1:0] Immed;
    logic [ADDR_W-1:0] Dest;
    logic [5:0]        Opcode;
    logic              Out_valid;

    modport master (
        output Instr, Instr_valid, Stall, Flush, RF_B_sel, ImmExt,
               RF_WrEn, RF_WrAddr, RF_WrData,
        input  RF_A, RF_B, Immed, Dest, Opcode, Out_valid
    );

    modport slave (
        input  Instr, Instr_valid, Stall, Flush, RF_B_sel, ImmExt,
               RF_WrEn, RF_WrAddr, RF_WrData,
        output RF_A, RF_B, Immed, Dest, Opcode, Out_valid
    );

endinterface

// File: rtl/dec_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// r0 hardwired to zero, cleared by the asynchronous active-low reset.
// Optional macro DEC_BYPASS_EN: a same-edge write to a nonzero read index
// is forwarded to that read port (write-first); otherwise read-first.
module dec_regfile
    import dec_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ra_addr_i,
    input  logic [ADDR_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0]  mem_q [REG_CNT];
    logic [REG_CNT-1:0] wr_sel;

    // One-hot write select; entry 0 is never selected so r0 stays zero.
    for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_wr_sel
        if (gi == 0) begin : g_r0
            assign wr_sel[gi] = 1'b0;
        end else begin : g_rn
            assign wr_sel[gi] = wr_en_i && (wr_addr_i == ADDR_W'(gi));
        end
    end

    // Register storage: cleared on reset, selected entry written each edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < REG_CNT; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < REG_CNT; i++)
                if (wr_sel[i]) mem_q[i] <= wr_data_i;
        end
    end

    // Read ports, with same-cycle forwarding when bypass is built in.
    always_comb begin
        ra_data_o = mem_q[ra_addr_i];
        rb_data_o = mem_q[rb_addr_i];
`ifdef DEC_BYPASS_EN
        if (wr_en_i && (wr_addr_i == ra_addr_i) && (ra_addr_i != '0))
            ra_data_o = wr_data_i;
        if (wr_en_i && (wr_addr_i == rb_addr_i) && (rb_addr_i != '0))
            rb_data_o = wr_data_i;
`endif
    end

endmodule

// File: rtl/dec_stage.sv
// Decode stage: field decode, immediate extension, operand read and the
// output pipeline register with stall (hold) and flush (bubble) control.
// Optional macro DEC_BYPASS_EN selects write-first operand reads.
module dec_stage
    import dec_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    dec_if.slave bus
);

    logic [DATA_W-1:0] a_q,   a_d;
    logic [DATA_W-1:0] b_q,   b_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [5:0]        opc_q,  opc_d;
    logic              vld_q,  vld_d;
    // Source indices of the instruction currently held, for stall re-reads.
    logic [ADDR_W-1:0] rs_q,  rs_d;
    logic [ADDR_W-1:0] rb_q,  rb_d;

    logic [DATA_W-1:0] word;
    logic              hold;
    logic [ADDR_W-1:0] rs_new, rb_new, ra_addr, rb_addr;
    logic [DATA_W-1:0] ra_data, rb_data;

    // A flush decodes a NOP as an invalid instruction, giving an all-zero
    // bubble; flush overrides stall.
    always_comb begin
        word    = bus.Flush ? NOP_INSTR : bus.Instr;
        hold    = bus.Stall && !bus.Flush;
        rs_new  = word[RS_MSB:RS_LSB];
        rb_new  = bus.RF_B_sel ? word[RD_MSB:RD_LSB] : word[RT_MSB:RT_LSB];
        ra_addr = hold ? rs_q : rs_new;
        rb_addr = hold ? rb_q : rb_new;
    end

    dec_regfile u_regfile (
        .Clk       (Clk),
        .Reset     (Reset),
        .ra_addr_i (ra_addr),
        .rb_addr_i (rb_addr),
        .ra_data_o (ra_data),
        .rb_data_o (rb_data),
        .wr_en_i   (bus.RF_WrEn),
        .wr_addr_i (bus.RF_WrAddr),
        .wr_data_i (bus.RF_WrData)
    );

    // Next-state of the output register: stall keeps the decoded fields but
    // refreshes the operands; otherwise capture the (possibly NOP) word.
    always_comb begin
        a_d    = ra_data;
        b_d    = rb_data;
        imm_d  = imm_q;
        dest_d = dest_q;
        opc_d  = opc_q;
        vld_d  = vld_q;
        rs_d   = rs_q;
        rb_d   = rb_q;
        if (!hold) begin
            imm_d  = extend_imm(word[IMM_MSB:IMM_LSB], imm_ext_e'(bus.ImmExt));
            dest_d = word[RT_MSB:RT_LSB];
            opc_d  = word[OPC_MSB:OPC_LSB];
            vld_d  = bus.Instr_valid && !bus.Flush;
            rs_d   = rs_new;
            rb_d   = rb_new;
        end
    end

    // Output pipeline register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
            dest_q <= '0;
            opc_q  <= '0;
            vld_q  <= 1'b0;
            rs_q   <= '0;
            rb_q   <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            imm_q  <= imm_d;
            dest_q <= dest_d;
            opc_q  <= opc_d;
            vld_q  <= vld_d;
            rs_q   <= rs_d;
            rb_q   <= rb_d;
        end
    end

    assign bus.RF_A      = a_q;
    assign bus.RF_B      = b_q;
    assign bus.Immed     = imm_q;
    assign bus.Dest      = dest_q;
    assign bus.Opcode    = opc_q;
    assign bus.Out_valid = vld_q;

endmodule

// File: tb/tb_dec_stage.sv
// Scoreboard bench for dec_stage: stimulus pushes the expected outputs
// computed by a behavioural model; a monitor pops and compares every cycle.
module tb_dec_stage;
    import dec_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    dec_if bus ();

    dec_stage dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [5:0]  opc;
        logic        vld;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_id  = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_held_instr;
    logic        m_held_bsel;
    exp_t        m_out;

    function automatic logic [31:0] model_imm(input logic [15:0] imm, input logic [1:0] mode);
        int s;
        s = imm[15] ? int'(imm) - 65536 : int'(imm);
        case (mode)
            2'd0:    return 32'(int'(imm));
            2'd1:    return 32'(s);
            2'd2:    return 32'(int'(imm) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wen,
                                               input logic [4:0] waddr, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'h0;
`ifdef DEC_BYPASS_EN
        if (wen && waddr == idx) return wdata;
`endif
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_held_instr = 32'h0;
        m_held_bsel  = 1'b0;
        m_out = '{a: 0, b: 0, imm: 0, dest: 0, opc: 0, vld: 0, id: 0};
    endtask

    // Called at a negedge: drives one cycle, pushes the expected outputs
    // after the coming posedge, then waits for the next negedge.
    task automatic drive(input logic [31:0] instr, input logic vld, input logic stall,
                         input logic flush, input logic bsel, input logic [1:0] ext,
                         input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
        exp_t e;
        logic [4:0] rs, rb;
        bus.Instr = instr;      bus.Instr_valid = vld;
        bus.Stall = stall;      bus.Flush = flush;
        bus.RF_B_sel = bsel;    bus.ImmExt = ext;
        bus.RF_WrEn = wen;      bus.RF_WrAddr = waddr;  bus.RF_WrData = wdata;
        if (flush) begin
            e = '{a: 0, b: 0, imm: 0, dest: 0, opc: 0, vld: 0, id: 0};
            m_held_instr = 32'h0;
            m_held_bsel  = 1'b0;
        end else if (stall) begin
            e  = m_out;
            rs = m_held_instr[25:21];
            rb = m_held_bsel ? m_held_instr[15:11] : m_held_instr[20:16];
            e.a = model_read(rs, wen, waddr, wdata);
            e.b = model_read(rb, wen, waddr, wdata);
        end else begin
            rs = instr[25:21];
            rb = bsel ? instr[15:11] : instr[20:16];
            e.a    = model_read(rs, wen, waddr, wdata);
            e.b    = model_read(rb, wen, waddr, wdata);
            e.imm  = model_imm(instr[15:0], ext);
            e.dest = instr[20:16];
            e.opc  = instr[31:26];
            e.vld  = vld;
            m_held_instr = instr;
            m_held_bsel  = bsel;
        end
        e.id = cyc_id;
        cyc_id++;
        m_out = e;
        sb_q.push_back(e);
        if (wen && waddr != 5'd0) m_regs[waddr] = wdata;
        @(negedge Clk);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    task automatic check_zero(input string name);
        n_tests++;
        if (bus.RF_A !== 0 || bus.RF_B !== 0 || bus.Immed !== 0 || bus.Dest !== 0 ||
            bus.Opcode !== 0 || bus.Out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got A=%h B=%h imm=%h dest=%0d opc=%0d vld=%b, required all zero",
                     name, bus.RF_A, bus.RF_B, bus.Immed, bus.Dest, bus.Opcode, bus.Out_valid);
        end
    endtask

    // Monitor: one scoreboard entry per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (bus.RF_A !== e.a || bus.RF_B !== e.b || bus.Immed !== e.imm ||
                    bus.Dest !== e.dest || bus.Opcode !== e.opc || bus.Out_valid !== e.vld) begin
                    n_fail++;
                    $display("FAIL cycle%0d: got A=%h B=%h imm=%h dest=%0d opc=%0d vld=%b, required A=%h B=%h imm=%h dest=%0d opc=%0d vld=%b",
                             e.id, bus.RF_A, bus.RF_B, bus.Immed, bus.Dest, bus.Opcode, bus.Out_valid,
                             e.a, e.b, e.imm, e.dest, e.opc, e.vld);
                end else begin
                    $display("[TB] cycle%0d ok A=%h B=%h imm=%h dest=%0d opc=%0d vld=%b",
                             e.id, e.a, e.b, e.imm, e.dest, e.opc, e.vld);
                end
            end
        end
    end

    task automatic random_cycles(input int n);
        logic [31:0] instr;
        for (int k = 0; k < n; k++) begin
            instr = $urandom;
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            instr[15:11] = 5'($urandom_range(0, 7));
            drive(instr, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge Clk);
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard still holds %0d entries, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        bus.Instr = 0;   bus.Instr_valid = 0; bus.Stall = 0; bus.Flush = 0;
        bus.RF_B_sel = 0; bus.ImmExt = 0; bus.RF_WrEn = 0; bus.RF_WrAddr = 0; bus.RF_WrData = 0;
        model_reset();
        #2 Reset = 1'b0;
        #1 check_zero("reset_initial");
        @(negedge Clk);
        Reset = 1'b1;

        // Write r5 then read it through rs
        drive(32'h0, 0, 0, 0, 0, 2'd0, 1, 5'd5, 32'hDEADBEEF);
        drive(mk(6'h23, 5'd5, 5'd0, 16'h0010), 1, 0, 0, 0, 2'd1, 0, 5'd0, 32'h0);
        // Write attempt to r0
        drive(32'h0, 0, 0, 0, 0, 2'd0, 1, 5'd0, 32'h12345678);
        drive(mk(6'h01, 5'd0, 5'd0, 16'h0), 1, 0, 0, 1, 2'd0, 0, 5'd0, 32'h0);
        // imm = 0x8004 under every extension mode
        for (int m = 0; m < 4; m++)
            drive(mk(6'h08, 5'd5, 5'd9, 16'h8004), 1, 0, 0, 0, 2'(m), 0, 5'd0, 32'h0);
        // Same-edge write and read of r7
        drive(mk(6'h02, 5'd7, 5'd7, 16'h0001), 1, 0, 0, 0, 2'd0, 1, 5'd7, 32'hA5A5A5A5);
        drive(mk(6'h02, 5'd7, 5'd7, 16'h0002), 1, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0);
        // Stall with a write-back to r3, then stall+flush
        drive(32'h0, 0, 0, 0, 0, 2'd0, 1, 5'd3, 32'h00000033);
        drive(mk(6'h2B, 5'd3, 5'd5, 16'hFFF0), 1, 0, 0, 0, 2'd1, 0, 5'd0, 32'h0);
        drive(mk(6'h3F, 5'd1, 5'd2, 16'h1234), 1, 1, 0, 0, 2'd2, 1, 5'd3, 32'hCAFE0003);
        drive(mk(6'h3E, 5'd4, 5'd6, 16'h4321), 0, 1, 0, 1, 2'd3, 0, 5'd0, 32'h0);
        drive(mk(6'h3D, 5'd3, 5'd5, 16'h7777), 1, 1, 1, 0, 2'd1, 0, 5'd0, 32'h0);
        drive(mk(6'h11, 5'd3, 5'd5, 16'h0042), 1, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0);

        random_cycles(300);

        // Reset mid-run: immediate clear, then all registers read back zero
        drain("drain_before_reset");
        Reset = 1'b0;
        model_reset();
        #1 check_zero("reset_midrun");
        @(negedge Clk);
        Reset = 1'b1;
        for (int r = 1; r < 32; r += 2)
            drive(mk(6'h05, 5'(r), 5'(r + 1), 16'h0), 1, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0);

        random_cycles(150);
        drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
